// File: rtl/ub_access_scheduler_if.sv
// Host-side bus of the unified-buffer access scheduler: the write handshake
// and the read-burst control/return path. master = host, slave = scheduler.
interface ub_access_scheduler_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 64,
  parameter int LENWIDTH    = 6
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDRESSSIZE-1:0] wr_addr;
  logic [WORDSIZE-1:0]    wr_data;
  logic                   rd_start;
  logic [ADDRESSSIZE-1:0] rd_base;
  logic [LENWIDTH-1:0]    rd_len;
  logic                   rd_busy;
  logic [WORDSIZE-1:0]    rd_data;
  logic                   rd_data_valid;
  logic                   rd_done;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len,
    input  wr_ready, rd_busy, rd_data, rd_data_valid, rd_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len,
    output wr_ready, rd_busy, rd_data, rd_data_valid, rd_done
  );
endinterface

// File: rtl/ub_access_scheduler.sv
// Unified-buffer access scheduler: arbitrates host writes and read bursts onto
// a single-port SRAM with one-cycle read latency. Writes are accepted only in
// IDLE; a burst issues one address per cycle (wrapping), then spends one DRAIN
// cycle collecting the last word.
// Optional feature: define UB_SCHED_STATS_EN to add the wr_stall_cycles and
// rd_words_total statistics outputs.
module ub_access_scheduler #(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 64,
  parameter int LENWIDTH    = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ub_access_scheduler_if.slave   bus,
  output logic                   sram_we,
  output logic [ADDRESSSIZE-1:0] sram_addr,
  output logic [WORDSIZE-1:0]    sram_din,
  input  logic [WORDSIZE-1:0]    sram_dout
`ifdef UB_SCHED_STATS_EN
  ,
  output logic [15:0]            wr_stall_cycles,
  output logic [15:0]            rd_words_total
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [LENWIDTH-1:0] LEN_ONE = LENWIDTH'(1);

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDRESSSIZE-1:0] r_base;
  logic [LENWIDTH-1:0]    r_len;
  logic [LENWIDTH-1:0]    r_idx;
  logic                   r_vld;
  logic                   r_done;
  logic                   w_start;
  logic                   w_last;

  // A zero-length request never leaves IDLE.
  assign w_start = (r_state == IDLE) && bus.rd_start && (bus.rd_len != '0);
  assign w_last  = (r_idx == (r_len - LEN_ONE));

  // Next-state and combinational SRAM/handshake drive.
  always_comb begin
    w_next       = r_state;
    bus.wr_ready = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_din     = '0;
    case (r_state)
      IDLE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) begin
          sram_we   = 1'b1;
          sram_addr = bus.wr_addr;
          sram_din  = bus.wr_data;
        end
        if (w_start) w_next = READ;
      end
      READ: begin
        sram_addr = r_base + ADDRESSSIZE'(r_idx);
        if (w_last) w_next = DRAIN;
      end
      DRAIN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Burst context: latched at start, index advances once per issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_len  <= '0;
      r_idx  <= '0;
    end else if (w_start) begin
      r_base <= bus.rd_base;
      r_len  <= bus.rd_len;
      r_idx  <= '0;
    end else if (r_state == READ) begin
      r_idx  <= r_idx + LEN_ONE;
    end
  end

  // Read-return qualifiers trail each issue by the SRAM's one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_vld  <= (r_state == READ);
      r_done <= (r_state == READ) && w_last;
    end
  end

  assign bus.rd_busy       = (r_state != IDLE);
  assign bus.rd_data_valid = r_vld;
  assign bus.rd_done       = r_done;
  // Data is forced to zero outside valid cycles so nothing leaks after reset.
  assign bus.rd_data       = r_vld ? sram_dout : '0;

`ifdef UB_SCHED_STATS_EN
  logic [15:0] r_stall;
  logic [15:0] r_words;

  // Saturating count of cycles in which a write was held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (bus.wr_valid && !bus.wr_ready && (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end

  // Wrapping count of delivered burst words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_words <= '0;
    else if (r_vld) r_words <= r_words + 16'd1;
  end

  assign wr_stall_cycles = r_stall;
  assign rd_words_total  = r_words;
`endif

endmodule

// File: tb/tb_ub_access_scheduler.sv
// Self-checking bench for ub_access_scheduler: directed scenarios plus a
// randomized phase, all checked every cycle against a burst-level reference
// model (remaining-word counter and a shadow memory).
module tb_ub_access_scheduler;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 6;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ub_access_scheduler_if #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .LENWIDTH(LW)) bus ();

  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
`ifdef UB_SCHED_STATS_EN
  logic [15:0]   wr_stall_cycles;
  logic [15:0]   rd_words_total;
`endif

  ub_access_scheduler #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .LENWIDTH(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
`ifdef UB_SCHED_STATS_EN
    ,
    .wr_stall_cycles (wr_stall_cycles),
    .rd_words_total  (rd_words_total)
`endif
  );

  // SRAM environment: synchronous, one-cycle read latency, cleared in reset.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sram_dout <= '0;
    end else begin
      if (sram_we) mem[sram_addr] <= sram_din;
      sram_dout <= mem[sram_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit m_active;
  int m_base, m_len, m_k;
  int m_stall, m_words;
  int n_obs_valid, n_obs_done;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_base = 0; m_len = 0; m_k = 0;
    m_stall = 0; m_words = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge,
  // then advance the model.
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rs, input logic [AW-1:0] rb, input logic [LW-1:0] rl);
    logic e_rdy, e_we, e_busy, e_vld, e_done;
    logic [DW-1:0] e_data;
    @(posedge clk);
    #1;
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_start = rs; bus.rd_base = rb; bus.rd_len = rl;
    @(negedge clk);
    e_data = '0;
    if (!m_active) begin
      e_rdy = 1'b1; e_we = wv; e_busy = 1'b0; e_vld = 1'b0; e_done = 1'b0;
    end else begin
      e_rdy = 1'b0; e_we = 1'b0; e_busy = 1'b1;
      e_vld = (m_k >= 1);
      e_done = (m_k == m_len);
      if (e_vld) e_data = ref_mem[(m_base + m_k - 1) % DEPTH];
    end
    chk("wr_ready", 64'(bus.wr_ready), 64'(e_rdy));
    chk("sram_we", 64'(sram_we), 64'(e_we));
    chk("rd_busy", 64'(bus.rd_busy), 64'(e_busy));
    chk("rd_data_valid", 64'(bus.rd_data_valid), 64'(e_vld));
    chk("rd_done", 64'(bus.rd_done), 64'(e_done));
    if (e_we) begin
      chk("wr_addr", 64'(sram_addr), 64'(wa));
      chk("wr_din", sram_din, wd);
    end
    if (m_active && m_k < m_len)
      chk("rd_addr", 64'(sram_addr), 64'((m_base + m_k) % DEPTH));
    if (e_vld) chk("rd_data", bus.rd_data, e_data);
`ifdef UB_SCHED_STATS_EN
    chk("wr_stall_cycles", 64'(wr_stall_cycles), 64'(m_stall));
    chk("rd_words_total", 64'(rd_words_total), 64'(m_words));
`endif
    if (bus.rd_data_valid === 1'b1) n_obs_valid++;
    if (bus.rd_done === 1'b1) n_obs_done++;
    if (e_vld) m_words = (m_words + 1) % 65536;
    if (wv && !e_rdy && m_stall < 65535) m_stall++;
    if (!m_active) begin
      if (wv) ref_mem[wa] = wd;
      if (rs && rl != 0) begin
        m_active = 1'b1; m_base = int'(rb); m_len = int'(rl); m_k = 0;
      end
    end else begin
      m_k++;
      if (m_k > m_len) m_active = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  int v0, d0;

  initial begin
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_start = 1'b0; bus.rd_base = '0; bus.rd_len = '0;
    model_reset();
    n_obs_valid = 0; n_obs_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.rd_busy), 64'd0);
    chk("rst_valid", 64'(bus.rd_data_valid), 64'd0);
    chk("rst_done", 64'(bus.rd_done), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    rst_n = 1'b1;

    // Single write then len=1 burst.
    step(1'b1, 10'd5, 64'h0123456789ABCDEF, 1'b0, '0, '0);
    v0 = n_obs_valid; d0 = n_obs_done;
    step(1'b0, '0, '0, 1'b1, 10'd5, 6'd1);
    idle(3);
    chk("single_valid_cnt", 64'(n_obs_valid - v0), 64'd1);
    chk("single_done_cnt", 64'(n_obs_done - d0), 64'd1);

    // Pre-load wrap region, then wrapping burst of 8.
    for (int i = 0; i < 8; i++)
      step(1'b1, AW'((1020 + i) % DEPTH), {$urandom, $urandom}, 1'b0, '0, '0);
    v0 = n_obs_valid;
    step(1'b0, '0, '0, 1'b1, 10'd1020, 6'd8);
    idle(10);
    chk("wrap_valid_cnt", 64'(n_obs_valid - v0), 64'd8);

    // Write held during a len=4 burst.
    step(1'b0, '0, '0, 1'b1, 10'd100, 6'd4);
    for (int i = 0; i < 6; i++) step(1'b1, 10'd200, 64'hDEADBEEF00000001, 1'b0, '0, '0);
    idle(2);

    // Same-cycle write and burst start on the same address.
    step(1'b1, 10'd9, 64'hAA, 1'b1, 10'd9, 6'd1);
    idle(3);

    // Zero-length start ignored; start during a burst ignored.
    v0 = n_obs_valid;
    step(1'b0, '0, '0, 1'b1, 10'd3, 6'd0);
    step(1'b0, '0, '0, 1'b1, 10'd0, 6'd5);
    step(1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 10'd40, 6'd7);
    idle(8);
    chk("ignore_valid_cnt", 64'(n_obs_valid - v0), 64'd5);

    // Maximum-length burst across the wrap point.
    v0 = n_obs_valid;
    step(1'b0, '0, '0, 1'b1, 10'd1000, 6'd63);
    idle(66);
    chk("maxlen_valid_cnt", 64'(n_obs_valid - v0), 64'd63);

    // Reset on the third word of a len=10 burst.
    d0 = n_obs_done;
    step(1'b0, '0, '0, 1'b1, 10'd1, 6'd10);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.rd_busy), 64'd0);
    chk("arst_valid", 64'(bus.rd_data_valid), 64'd0);
    chk("arst_done", 64'(bus.rd_done), 64'd0);
    chk("arst_we", 64'(sram_we), 64'd0);
    chk("arst_rd_data", bus.rd_data, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("arst_no_done", 64'(n_obs_done - d0), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] wa, rb;
      wa = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1016, 1023)) : AW'($urandom_range(0, 31));
      rb = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1016, 1023)) : AW'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
           1'($urandom_range(0, 7) == 0), rb, LW'($urandom_range(0, 12)));
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ub_access_scheduler.md
UB_ACCESS_SCHEDULER -- requirements
Module: ub_access_scheduler

Interface
REQ-001 Parameter ADDRESSSIZE, default 10, SHALL set the SRAM word-address width.
REQ-002 Parameter WORDSIZE, default 64, SHALL set the data word width (8 bytes).
REQ-003 Parameter LENWIDTH, default 6, SHALL set the burst-length field width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 wr_valid  input  1  SHALL mean a host write request is present.
REQ-007 wr_ready  output  1  SHALL mean the scheduler accepts the write this cycle.
REQ-008 wr_addr  input  ADDRESSSIZE  SHALL carry the write word address.
REQ-009 wr_data  input  WORDSIZE  SHALL carry the write data.
REQ-010 rd_start  input  1  SHALL be a one-cycle request to start a read burst.
REQ-011 rd_base  input  ADDRESSSIZE  SHALL carry the burst start address, sampled with rd_start.
REQ-012 rd_len  input  LENWIDTH  SHALL carry the word count, sampled with rd_start.
REQ-013 rd_busy  output  1  SHALL be high while a burst is in progress.
REQ-014 rd_data  output  WORDSIZE  SHALL carry burst read data.
REQ-015 rd_data_valid  output  1  SHALL qualify rd_data.
REQ-016 rd_done  output  1  SHALL pulse for one cycle with the last burst word.
REQ-017 sram_we, sram_addr (ADDRESSSIZE), sram_din (WORDSIZE)  outputs  SHALL drive the unified buffer SRAM write_enable, address, and data_in.
REQ-018 sram_dout  input  WORDSIZE  SHALL receive SRAM data_out (one-cycle read latency).

Function
REQ-019 The FSM SHALL have three states: IDLE, READ, and DRAIN.
REQ-020 In IDLE, wr_ready SHALL be 1. In READ and DRAIN, wr_ready SHALL be 0.
REQ-021 A write SHALL occur when wr_valid and wr_ready are both high: sram_we=1, sram_addr=wr_addr, sram_din=wr_data in that same cycle (combinational).
REQ-022 In IDLE, rd_start with rd_len!=0 SHALL latch rd_base and rd_len and move to READ in the next cycle; rd_len=0 SHALL be ignored.
REQ-023 If rd_start and a write arrive in the same IDLE cycle, both SHALL be accepted: the write is issued that cycle and the burst starts the next cycle, so the reads observe the written data.
REQ-024 In READ, the scheduler SHALL issue one read per cycle with sram_we=0 and sram_addr=(base+i) mod 2^ADDRESSSIZE, for i=0..len-1.
REQ-025 After issuing the last address, the FSM SHALL move to DRAIN for one cycle, then return to IDLE.
REQ-026 rd_data_valid SHALL be registered high exactly one cycle after each read issue; rd_data SHALL equal sram_dout.
REQ-027 rd_done SHALL be high in the same cycle as the final rd_data_valid (the DRAIN cycle).
REQ-028 rd_busy SHALL be high in READ and DRAIN.
REQ-029 rd_start while rd_busy is high SHALL be ignored.
REQ-030 In IDLE with no write, sram_we SHALL be 0 and sram_addr SHALL be don't-care.
REQ-031 Addresses SHALL wrap at 2^ADDRESSSIZE-1 to 0 without error.
REQ-032 A burst of maximum length SHALL be 2^LENWIDTH-1 words.

Reset
REQ-033 On rst_n low, the following SHALL be forced asynchronously:
- state = IDLE
- rd_busy, rd_data_valid, rd_done = 0
- latched base, length, and index = 0
REQ-034 Reset during a burst SHALL abort it with no rd_done; after rst_n rises, wr_ready SHALL be 1 on the first clock.

Configuration
REQ-035 With macro UB_SCHED_STATS_EN defined, the following SHALL be added:
- output wr_stall_cycles [15:0]: counts cycles with wr_valid=1 and wr_ready=0, saturating at 16'hFFFF, reset to 0.
- output rd_words_total [15:0]: counts rd_data_valid cycles, wrapping.
REQ-036 Without UB_SCHED_STATS_EN, these ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-037 Write 0x0123456789ABCDEF to addr 5, then rd_start base=5 len=1 -> one rd_data_valid with 0x0123456789ABCDEF, rd_done in the same cycle, rd_busy high for 2 cycles.
REQ-038 Burst base=1020 len=8 (ADDRESSSIZE=10) -> sram_addr sequence 1020..1023, 0..3; 8 valid words; rd_done on the 8th.
REQ-039 wr_valid held high during a len=4 burst -> wr_ready=0 for 5 cycles, write issued in the first IDLE cycle; with UB_SCHED_STATS_EN, wr_stall_cycles=5.
REQ-040 Same-cycle write addr 9 = 0xAA and rd_start base=9 len=1 -> rd_data=0xAA.
REQ-041 rd_len=0, and a second rd_start mid-burst -> both ignored; total valid count equals the first burst length only.
REQ-042 rst_n asserted on the 3rd word of a len=10 burst -> all outputs 0 immediately, no rd_done, wr_ready=1 on the first clock after release.
